// File: rtl/sifre_giris_denetleyici.sv
// Two-button password lock sequencer: button sync/debounce, enroll,
// verify, failed-attempt lockout and RGB LED pattern.
module sifre_giris_denetleyici #(
    parameter int CODE_LEN   = 6,
    parameter int MAX_TRY    = 3,
    parameter int DEB_CYC    = 500_000,
    parameter int BLINK_HALF = 10_000_000,
    parameter int HOLD_CYC   = 50_000_000,
    parameter int LOCK_CYC   = 200_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       butonA,
    input  logic       butonB,
    output logic [2:0] led,
    output logic [2:0] durum,
    output logic [3:0] hane_say,
    output logic [2:0] hata_say,
    output logic       acildi
);

    localparam int DW = $clog2(DEB_CYC);
    localparam int BW = $clog2(BLINK_HALF);
    localparam int HW = $clog2(HOLD_CYC);
    localparam int LW = $clog2(LOCK_CYC);

    typedef enum logic [2:0] {
        S_ENROLL = 3'd0,
        S_VERIFY = 3'd1,
        S_PASS   = 3'd2,
        S_FAIL   = 3'd3,
        S_LOCKED = 3'd4
    } state_t;

    logic [1:0] syncA, syncB;
    logic [1:0] syncPat, lastPat, debPat;
    logic [DW-1:0] debCnt;
    logic digPulse, digVal;

    always_ff @(posedge clk) begin
        if (rst) begin
            syncA <= 2'b11;
            syncB <= 2'b11;
        end else begin
            syncA <= {syncA[0], butonA};
            syncB <= {syncB[0], butonB};
        end
    end

    assign syncPat = {syncA[1], syncB[1]};

    // A digit is only the first settled move away from "both released".
    always_ff @(posedge clk) begin
        if (rst) begin
            lastPat  <= 2'b11;
            debPat   <= 2'b11;
            debCnt   <= '0;
            digPulse <= 1'b0;
            digVal   <= 1'b0;
        end else begin
            digPulse <= 1'b0;
            if (syncPat != lastPat) begin
                lastPat <= syncPat;
                debCnt  <= '0;
            end else if (syncPat == debPat) begin
                debCnt <= '0;
            end else if (debCnt == DW'(DEB_CYC - 1)) begin
                debPat   <= syncPat;
                debCnt   <= '0;
                digPulse <= (debPat == 2'b11) &&
                            (syncPat == 2'b01 || syncPat == 2'b10);
                digVal   <= (syncPat == 2'b10);
            end else begin
                debCnt <= debCnt + 1'b1;
            end
        end
    end

    state_t state, stateN;
    logic [HW-1:0] holdT, holdTN;
    logic [LW-1:0] lockT, lockTN;
    logic [BW-1:0] blinkCnt, blinkCntN;
    logic blinkOn, blinkOnN;
    logic [CODE_LEN-1:0] code, codeN, shiftR, shiftN, fullCode;
    logic [3:0] haneR, haneN;
    logic [2:0] hataR, hataN, hataInc;
    logic acildiR, acildiN;
    logic [2:0] ledR, ledN;
    logic lastDig;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_ENROLL;
            holdT    <= '0;
            lockT    <= '0;
            blinkCnt <= '0;
            blinkOn  <= 1'b1;
            code     <= '0;
            shiftR   <= '0;
            haneR    <= '0;
            hataR    <= '0;
            acildiR  <= 1'b0;
            ledR     <= 3'b111;
        end else begin
            state    <= stateN;
            holdT    <= holdTN;
            lockT    <= lockTN;
            blinkCnt <= blinkCntN;
            blinkOn  <= blinkOnN;
            code     <= codeN;
            shiftR   <= shiftN;
            haneR    <= haneN;
            hataR    <= hataN;
            acildiR  <= acildiN;
            ledR     <= ledN;
        end
    end

    always_comb begin
        stateN   = state;
        holdTN   = '0;
        lockTN   = '0;
        codeN    = code;
        shiftN   = shiftR;
        haneN    = haneR;
        hataN    = hataR;
        acildiN  = 1'b0;
        fullCode = shiftR | (CODE_LEN'(digVal) << haneR);
        lastDig  = (haneR == 4'(CODE_LEN - 1));
        hataInc  = hataR + 3'd1;
        if (blinkCnt == BW'(BLINK_HALF - 1)) begin
            blinkCntN = '0;
            blinkOnN  = ~blinkOn;
        end else begin
            blinkCntN = blinkCnt + 1'b1;
            blinkOnN  = blinkOn;
        end

        unique case (state)
            S_ENROLL: begin
                if (digPulse) begin
                    if (lastDig) begin
                        codeN  = fullCode;
                        shiftN = '0;
                        haneN  = '0;
                        stateN = S_VERIFY;
                    end else begin
                        shiftN = fullCode;
                        haneN  = haneR + 4'd1;
                    end
                end
            end
            S_VERIFY: begin
                if (digPulse) begin
                    if (lastDig) begin
                        shiftN = '0;
                        haneN  = '0;
                        if (fullCode == code) begin
                            stateN  = S_PASS;
                            hataN   = '0;
                            acildiN = 1'b1;
                        end else begin
                            hataN  = hataInc;
                            stateN = (hataInc == 3'(MAX_TRY)) ?
                                     S_LOCKED : S_FAIL;
                        end
                    end else begin
                        shiftN = fullCode;
                        haneN  = haneR + 4'd1;
                    end
                end
            end
            S_PASS: begin
                if (debPat == 2'b00) begin
                    stateN = S_ENROLL;
                    hataN  = '0;
                    haneN  = '0;
                    shiftN = '0;
                end
            end
            S_FAIL: begin
                holdTN = holdT + 1'b1;
                if (holdT == HW'(HOLD_CYC - 1))
                    stateN = S_VERIFY;
            end
            S_LOCKED: begin
                lockTN = lockT + 1'b1;
                if (lockT == LW'(LOCK_CYC - 1)) begin
                    stateN = S_VERIFY;
                    hataN  = '0;
                end
            end
            default: stateN = S_ENROLL;
        endcase

        // Fresh timers and a lit blink phase on every state entry.
        if (stateN != state) begin
            holdTN    = '0;
            lockTN    = '0;
            blinkCntN = '0;
            blinkOnN  = 1'b1;
        end

        unique case (stateN)
            S_ENROLL: ledN = blinkOnN ? 3'b101 : 3'b111;
            S_VERIFY: ledN = blinkOnN ? 3'b110 : 3'b111;
            S_PASS:   ledN = 3'b110;
            S_FAIL:   ledN = 3'b011;
            S_LOCKED: ledN = blinkOnN ? 3'b011 : 3'b111;
            default:  ledN = 3'b111;
        endcase
    end

    assign led      = ledR;
    assign durum    = state;
    assign hane_say = haneR;
    assign hata_say = hataR;
    assign acildi   = acildiR;

endmodule

// File: tb/tb_sifre_giris_denetleyici.sv
// Directed bench for the password lock sequencer with shortened
// debounce, blink, hold and lockout periods.
module tb_sifre_giris_denetleyici;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic butonA = 1'b1;
    logic butonB = 1'b1;
    logic [2:0] led, durum, hata_say;
    logic [3:0] hane_say;
    logic acildi;

    int vecs = 0;
    int miss = 0;

    localparam logic [5:0] CODE1 = 6'b101101;
    localparam logic [5:0] CODE2 = 6'b000000;

    sifre_giris_denetleyici #(
        .CODE_LEN(6), .MAX_TRY(3), .DEB_CYC(4),
        .BLINK_HALF(8), .HOLD_CYC(16), .LOCK_CYC(32)
    ) dut (
        .clk(clk), .rst(rst), .butonA(butonA), .butonB(butonB),
        .led(led), .durum(durum), .hane_say(hane_say),
        .hata_say(hata_say), .acildi(acildi)
    );

    always #5 clk = ~clk;

    int acTotal = 0;
    int failRun = 0, lastFailLen = 0, failEps = 0, failLedBad = 0;
    int lockRun = 0, lastLockLen = 0;
    logic [2:0] lockLed0 = 3'b000, lockLed8 = 3'b000;

    always @(negedge clk) begin
        if (acildi) acTotal <= acTotal + 1;
        if (durum == 3'd3) begin
            failRun <= failRun + 1;
            if (led !== 3'b011) failLedBad <= failLedBad + 1;
        end else if (failRun != 0) begin
            lastFailLen <= failRun;
            failEps <= failEps + 1;
            failRun <= 0;
        end
        if (durum == 3'd4) begin
            if (lockRun == 0) lockLed0 <= led;
            if (lockRun == 8) lockLed8 <= led;
            lockRun <= lockRun + 1;
        end else if (lockRun != 0) begin
            lastLockLen <= lockRun;
            lockRun <= 0;
        end
    end

    task automatic press(input bit d, input int holdN, input int relN);
        @(negedge clk);
        if (d) butonB = 1'b0;
        else butonA = 1'b0;
        repeat (holdN) @(negedge clk);
        butonA = 1'b1;
        butonB = 1'b1;
        repeat (relN) @(negedge clk);
    endtask

    task automatic enterCode(input logic [5:0] c, input int lastRel);
        for (int i = 0; i < 6; i++)
            press(c[i], 12, (i == 5) ? lastRel : 14);
    endtask

    task automatic waitDurum(input logic [2:0] s, input int budget,
                             output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (durum === s) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        vecs++;
        if (durum !== 3'd0) begin
            $display("FAIL rst_durum got=%0d exp=0", durum); miss++;
        end
        vecs++;
        if (led !== 3'b111) begin
            $display("FAIL rst_led got=%b exp=111", led); miss++;
        end
        vecs++;
        if (hane_say !== 4'd0) begin
            $display("FAIL rst_hane got=%0d exp=0", hane_say); miss++;
        end
        vecs++;
        if (hata_say !== 3'd0) begin
            $display("FAIL rst_hata got=%0d exp=0", hata_say); miss++;
        end
        vecs++;
        if (acildi !== 1'b0) begin
            $display("FAIL rst_acildi got=%b exp=0", acildi); miss++;
        end
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (led !== 3'b101) begin
            $display("FAIL enroll_led got=%b exp=101", led); miss++;
        end
    endtask

    task automatic test_enroll(input logic [5:0] c);
        for (int i = 0; i < 6; i++) begin
            press(c[i], 12, 14);
            if (i < 5) begin
                vecs++;
                if (hane_say !== 4'(i + 1) || durum !== 3'd0) begin
                    $display("FAIL enroll_digit%0d hane=%0d durum=%0d exp hane=%0d durum=0",
                             i, hane_say, durum, i + 1);
                    miss++;
                end
            end
        end
        vecs++;
        if (durum !== 3'd1 || hane_say !== 4'd0) begin
            $display("FAIL enroll_done durum=%0d hane=%0d exp durum=1 hane=0",
                     durum, hane_say);
            miss++;
        end
        vecs++;
        if (led !== 3'b110 && led !== 3'b111) begin
            $display("FAIL verify_led got=%b exp=110/111", led); miss++;
        end
    endtask

    task automatic test_glitch_and_fail;
        bit ok;
        int eps0;
        butonA = 1'b0;
        repeat (2) @(negedge clk);
        butonA = 1'b1;
        repeat (14) @(negedge clk);
        vecs++;
        if (hane_say !== 4'd0) begin
            $display("FAIL glitch hane=%0d exp=0", hane_say); miss++;
        end
        press(1'b0, 40, 14);
        vecs++;
        if (hane_say !== 4'd1) begin
            $display("FAIL long_hold hane=%0d exp=1", hane_say); miss++;
        end
        eps0 = failEps;
        for (int i = 1; i < 6; i++) press(CODE1[i], 12, (i == 5) ? 4 : 14);
        vecs++;
        if (durum !== 3'd3 || hata_say !== 3'd1) begin
            $display("FAIL wrong1 durum=%0d hata=%0d exp durum=3 hata=1",
                     durum, hata_say);
            miss++;
        end
        waitDurum(3'd1, 40, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok) begin
            $display("FAIL fail_exit timeout durum=%0d exp=1", durum); miss++;
        end
        vecs++;
        if (lastFailLen !== 16 || failEps - eps0 !== 1) begin
            $display("FAIL fail_len got=%0d eps=%0d exp 16 eps=1",
                     lastFailLen, failEps - eps0);
            miss++;
        end
        vecs++;
        if (failLedBad !== 0) begin
            $display("FAIL fail_led bad=%0d exp=0", failLedBad); miss++;
        end
    endtask

    task automatic test_both_low;
        bit ok;
        press(1'b1, 12, 14);
        @(negedge clk);
        butonA = 1'b0;
        butonB = 1'b0;
        repeat (12) @(negedge clk);
        butonA = 1'b1;
        butonB = 1'b1;
        repeat (14) @(negedge clk);
        vecs++;
        if (hane_say !== 4'd1 || durum !== 3'd1) begin
            $display("FAIL both_low hane=%0d durum=%0d exp hane=1 durum=1",
                     hane_say, durum);
            miss++;
        end
        for (int i = 1; i < 6; i++) press(1'b0, 12, 14);
        waitDurum(3'd1, 40, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok || hata_say !== 3'd2) begin
            $display("FAIL wrong2 durum=%0d hata=%0d exp durum=1 hata=2",
                     durum, hata_say);
            miss++;
        end
    endtask

    task automatic test_lockout;
        bit ok;
        int ac0;
        enterCode(6'b000000, 2);
        vecs++;
        if (durum !== 3'd4 || hata_say !== 3'd3) begin
            $display("FAIL lock_enter durum=%0d hata=%0d exp durum=4 hata=3",
                     durum, hata_say);
            miss++;
        end
        press(1'b1, 12, 4);
        vecs++;
        if (durum !== 3'd4 || hane_say !== 4'd0) begin
            $display("FAIL lock_ignore durum=%0d hane=%0d exp durum=4 hane=0",
                     durum, hane_say);
            miss++;
        end
        waitDurum(3'd1, 40, ok);
        repeat (2) @(negedge clk);
        vecs++;
        if (!ok || hata_say !== 3'd0) begin
            $display("FAIL lock_exit durum=%0d hata=%0d exp durum=1 hata=0",
                     durum, hata_say);
            miss++;
        end
        vecs++;
        if (lastLockLen !== 32) begin
            $display("FAIL lock_len got=%0d exp=32", lastLockLen); miss++;
        end
        vecs++;
        if (lockLed0 !== 3'b011 || lockLed8 !== 3'b111) begin
            $display("FAIL lock_blink got=%b/%b exp=011/111", lockLed0, lockLed8);
            miss++;
        end
        repeat (10) @(negedge clk);
        ac0 = acTotal;
        enterCode(CODE1, 14);
        vecs++;
        if (durum !== 3'd2 || led !== 3'b110) begin
            $display("FAIL pass durum=%0d led=%b exp durum=2 led=110", durum, led);
            miss++;
        end
        vecs++;
        if (acTotal - ac0 !== 1) begin
            $display("FAIL acildi_pulse got=%0d cycles exp=1", acTotal - ac0);
            miss++;
        end
    endtask

    task automatic test_reenroll_and_reset;
        bit ok;
        int ac0;
        @(negedge clk);
        butonA = 1'b0;
        butonB = 1'b0;
        waitDurum(3'd0, 30, ok);
        butonA = 1'b1;
        butonB = 1'b1;
        repeat (14) @(negedge clk);
        vecs++;
        if (!ok || hata_say !== 3'd0 || durum !== 3'd0) begin
            $display("FAIL reenroll durum=%0d hata=%0d exp durum=0 hata=0",
                     durum, hata_say);
            miss++;
        end
        for (int i = 0; i < 3; i++) press(1'b0, 12, 14);
        vecs++;
        if (hane_say !== 4'd3) begin
            $display("FAIL three_digits hane=%0d exp=3", hane_say); miss++;
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        vecs++;
        if (durum !== 3'd0 || hane_say !== 4'd0) begin
            $display("FAIL mid_rst durum=%0d hane=%0d exp durum=0 hane=0",
                     durum, hane_say);
            miss++;
        end
        test_enroll(CODE2);
        enterCode(CODE1, 4);
        vecs++;
        if (durum !== 3'd3 || hata_say !== 3'd1) begin
            $display("FAIL old_code durum=%0d hata=%0d exp durum=3 hata=1",
                     durum, hata_say);
            miss++;
        end
        waitDurum(3'd1, 40, ok);
        repeat (4) @(negedge clk);
        ac0 = acTotal;
        enterCode(CODE2, 14);
        vecs++;
        if (!ok || durum !== 3'd2 || acTotal - ac0 !== 1) begin
            $display("FAIL new_code durum=%0d pulses=%0d exp durum=2 pulses=1",
                     durum, acTotal - ac0);
            miss++;
        end
    endtask

    initial begin
        test_reset;
        test_enroll(CODE1);
        test_glitch_and_fail;
        test_both_low;
        test_lockout;
        test_reenroll_and_reset;
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
